lbm_stream_engine: RTL and testbench

//  Parametrised D2Q9 streaming engine. Streams one direction plane per sweep, one cell/clock, fully pipelined.

---
 rtl/lbm_stream_engine.sv | 191 +++++++++++++++++++
 tb/tb_lbm_stream_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lbm_stream_engine.sv
// D2Q9 streaming engine: one direction plane per sweep, one cell per clock, with wrap, wall and barrier bounce-back.
// Latency: a write lands RD_LAT+1 cycles after its read. There is no backpressure; the BRAMs must accept a read and a write every cycle.
module lbm_stream_engine #(
  parameter int WIDTH  = 80,
  parameter int HEIGHT = 40,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        dir,
  input  logic              wrap_x,
  input  logic              wrap_y,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       sweep_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] bar_addr,
  input  logic              bar_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_opp
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic              wall;
    logic              bar_ok;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
  } pipe_t;

  state_t            state, state_nx;
  logic [3:0]        dir_r;
  logic              wrap_x_r, wrap_y_r, inv_r;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        drain_cnt;
  logic              start_ok, start_bad, last_cell;
  logic              dx_pos, dx_neg, dy_pos, dy_neg;
  logic              x_lo, x_hi, y_lo, y_hi, wall, bar_ok, bounce;
  logic [ADDR_W-1:0] dest;
  pipe_t             pipe [RD_LAT];
  pipe_t             tail;

  assign start_ok  = start && (state == S_IDLE) && (dir <= 4'd8);
  assign start_bad = start && (state == S_IDLE) && (dir >  4'd8);
  assign last_cell = (addr == ADDR_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_SWEEP;
               else if (start_bad) state_nx = S_DONE;
      S_SWEEP: if (last_cell) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == 3'(RD_LAT)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    rd_en = (state == S_SWEEP);
    done  = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r       <= '0;
      wrap_x_r    <= 1'b0;
      wrap_y_r    <= 1'b0;
      inv_r       <= 1'b0;
      err         <= 1'b0;
      sweep_count <= '0;
      drain_cnt   <= '0;
    end else begin
      if (start_ok || start_bad) begin
        dir_r    <= dir;
        wrap_x_r <= wrap_x;
        wrap_y_r <= wrap_y;
        inv_r    <= start_bad;
        err      <= start_bad;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      if (state == S_DONE && !inv_r) sweep_count <= sweep_count + 16'd1;
    end
  end

  // Raster counters return to zero after the last cell, so the next sweep starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (state == S_SWEEP) begin
      addr <= last_cell ? '0 : addr + ADDR_W'(1);
      if (x == XW'(WIDTH - 1)) begin
        x <= '0;
        y <= (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_comb begin
    dx_pos = 1'b0;
    dx_neg = 1'b0;
    dy_pos = 1'b0;
    dy_neg = 1'b0;
    case (dir_r)
      4'd1: dy_neg = 1'b1;
      4'd2: begin dx_pos = 1'b1; dy_neg = 1'b1; end
      4'd3: dx_pos = 1'b1;
      4'd4: begin dx_pos = 1'b1; dy_pos = 1'b1; end
      4'd5: dy_pos = 1'b1;
      4'd6: begin dx_neg = 1'b1; dy_pos = 1'b1; end
      4'd7: dx_neg = 1'b1;
      4'd8: begin dx_neg = 1'b1; dy_neg = 1'b1; end
      default: ;
    endcase
  end

  assign x_lo   = dx_neg && (x == '0);
  assign x_hi   = dx_pos && (x == XW'(WIDTH - 1));
  assign y_lo   = dy_neg && (y == '0);
  assign y_hi   = dy_pos && (y == YW'(HEIGHT - 1));
  assign wall   = ((x_lo || x_hi) && !wrap_x_r) || ((y_lo || y_hi) && !wrap_y_r);
  assign bar_ok = !wall && (dir_r != 4'd0);

  // Destination built from the source address with constant offsets; modular
  // ADDR_W arithmetic is safe because every wrapped result lands in range.
  always_comb begin
    dest = addr;
    if (dx_pos) dest = x_hi ? dest - ADDR_W'(WIDTH - 1) : dest + ADDR_W'(1);
    if (dx_neg) dest = x_lo ? dest + ADDR_W'(WIDTH - 1) : dest - ADDR_W'(1);
    if (dy_pos) dest = y_hi ? dest - ADDR_W'(N - WIDTH) : dest + ADDR_W'(WIDTH);
    if (dy_neg) dest = y_lo ? dest + ADDR_W'(N - WIDTH) : dest - ADDR_W'(WIDTH);
  end

  assign rd_addr  = addr;
  assign bar_addr = wall ? addr : dest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: rd_en, wall: wall, bar_ok: bar_ok, src: addr, dst: dest};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail   = pipe[RD_LAT-1];
  assign bounce = tail.wall || (tail.bar_ok && bar_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_opp  <= 1'b0;
    end else begin
      wr_en <= tail.vld;
      if (tail.vld) begin
        wr_addr <= bounce ? tail.src : tail.dst;
        wr_opp  <= bounce;
        wr_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_lbm_stream_engine.sv
// Bench for lbm_stream_engine on a 4x3 grid with a one-cycle BRAM model; source word at address a is 0x100+a.
module tb_lbm_stream_engine;
  localparam int W = 4, H = 3, N = 12, DW = 16, AW = 12, RL = 1;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]    dir = '0;
  logic          wrap_x = 1'b0, wrap_y = 1'b0;
  logic          busy, done, err, rd_en, bar_data, wr_en, wr_opp;
  logic [15:0]   sweep_count;
  logic [AW-1:0] rd_addr, bar_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;
  bit            bar_mem [N];

  lbm_stream_engine #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .wrap_x(wrap_x), .wrap_y(wrap_y),
    .busy(busy), .done(done), .err(err), .sweep_count(sweep_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .bar_addr(bar_addr), .bar_data(bar_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_opp(wr_opp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    rd_data  <= 16'h100 + 16'(rd_addr);
    bar_data <= (int'(bar_addr) < N) ? bar_mem[bar_addr] : 1'b0;
  end

  typedef struct {int addr; int data; int opp;} wr_t;
  wr_t q[$];

  int n_checks = 0, n_fail = 0, exp_count = 0;
  int c0 = 0, first_rd, last_rd, n_rd, first_wr, last_wr, n_wr, done_rel, busy_first, busy_last;
  int got_addr [N], got_opp [N], hits [N];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    first_rd = -1; last_rd = -1; n_rd = 0;
    first_wr = -1; last_wr = -1; n_wr = 0;
    done_rel = -1; busy_first = -1; busy_last = -1;
    for (int i = 0; i < N; i++) begin got_addr[i] = -1; got_opp[i] = -1; hits[i] = 0; end
  endtask

  function automatic void model(input int a, input int d, input bit wx, input bit wy,
                                output int ea, output int eo);
    int x = a % W, y = a / W, dx = 0, dy = 0, nx, ny;
    bit wall = 1'b0;
    case (d)
      1: dy = -1;
      2: begin dx = 1;  dy = -1; end
      3: dx = 1;
      4: begin dx = 1;  dy = 1;  end
      5: dy = 1;
      6: begin dx = -1; dy = 1;  end
      7: dx = -1;
      8: begin dx = -1; dy = -1; end
      default: ;
    endcase
    nx = x + dx;
    ny = y + dy;
    if (nx < 0 || nx >= W) begin if (wx) nx = (nx + W) % W; else wall = 1'b1; end
    if (ny < 0 || ny >= H) begin if (wy) ny = (ny + H) % H; else wall = 1'b1; end
    if (d == 0) begin ea = a; eo = 0; end
    else if (wall) begin ea = a; eo = 1; end
    else if (bar_mem[ny*W + nx]) begin ea = a; eo = 1; end
    else begin ea = ny*W + nx; eo = 0; end
  endfunction

  task automatic push_sweep(input int d, input bit wx, input bit wy);
    int ea, eo;
    for (int a = 0; a < N; a++) begin
      model(a, d, wx, wy, ea, eo);
      q.push_back('{ea, 256 + a, eo});
    end
  endtask

  // Monitor: records timing relative to the start cycle and scores every write.
  always @(negedge clk) begin
    int rel, idx;
    wr_t e;
    rel = cyc - c0;
    if (rd_en) begin n_rd++; if (first_rd < 0) first_rd = rel; last_rd = rel; end
    if (busy)  begin if (busy_first < 0) busy_first = rel; busy_last = rel; end
    if (done)  done_rel = rel;
    if (wr_en) begin
      n_wr++;
      if (first_wr < 0) first_wr = rel;
      last_wr = rel;
      if (int'(wr_addr) < N) hits[wr_addr]++;
      idx = int'(wr_data) - 256;
      if (idx >= 0 && idx < N) begin got_addr[idx] = int'(wr_addr); got_opp[idx] = int'(wr_opp); end
      check("write_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        check("wr_opp",  wr_opp,  e.opp);
      end
    end
  end

  task automatic do_sweep(input int d, input bit wx, input bit wy, input bit glitch);
    clear_stats();
    if (d <= 8) push_sweep(d, wx, wy);
    @(posedge clk); #1;
    c0 = cyc; dir = 4'(d); wrap_x = wx; wrap_y = wy; start = 1'b1;
    for (int i = 0; i < 60 && done_rel < 0; i++) begin
      @(posedge clk); #1;
      start = glitch && ((cyc - c0) == 5 || (cyc - c0) == 15);
      if (start) dir = 4'd7;
    end
    start = 1'b0;
    check("done_seen", done_rel >= 0, 1);
    check("busy_after_done", busy, 0);
    if (d <= 8) begin
      exp_count++;
      check("done_cycle", done_rel, N + RL + 2);
      check("rd_first", first_rd, 1);
      check("rd_last", last_rd, N);
      check("wr_first", first_wr, RL + 2);
      check("wr_last", last_wr, N + RL + 1);
      check("busy_first", busy_first, 1);
      check("busy_last", busy_last, N + RL + 2);
    end else begin
      check("done_cycle", done_rel, 1);
    end
    check("n_rd", n_rd, (d <= 8) ? N : 0);
    check("n_wr", n_wr, (d <= 8) ? N : 0);
    check("queue_empty", q.size(), 0);
    check("sweep_count", sweep_count, exp_count);
    q.delete();
  endtask

  initial begin
    int ones;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);   check("rst_done", done, 0);   check("rst_err", err, 0);
    check("rst_rd_en", rd_en, 0); check("rst_wr_en", wr_en, 0); check("rst_count", sweep_count, 0);
    check("rst_rd_addr", rd_addr, 0); check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0); check("rst_wr_opp", wr_opp, 0); check("rst_bar_addr", bar_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // East with x wrap, plus stray starts mid-sweep and on the done cycle
    do_sweep(3, 1'b1, 1'b0, 1'b1);
    check("e_wrap_addr7", got_addr[7], 4); check("e_wrap_opp7", got_opp[7], 0);
    ones = 0;
    for (int i = 0; i < N; i++) if (hits[i] == 1) ones++;
    check("e_wrap_each_once", ones, N);

    do_sweep(3, 1'b0, 1'b0, 1'b0);
    check("e_wall_addr7", got_addr[7], 7); check("e_wall_opp7", got_opp[7], 1);
    check("e_wall_addr5", got_addr[5], 6); check("e_wall_opp5", got_opp[5], 0);

    bar_mem[2] = 1'b1;
    do_sweep(1, 1'b0, 1'b1, 1'b0);
    check("n_bar_addr6", got_addr[6], 6); check("n_bar_opp6", got_opp[6], 1);
    check("n_wrap_addr2", got_addr[2], 10); check("n_wrap_opp2", got_opp[2], 0);
    bar_mem[2] = 1'b0;

    do_sweep(2, 1'b1, 1'b1, 1'b0);
    check("ne_wrap_addr3", got_addr[3], 8); check("ne_wrap_opp3", got_opp[3], 0);
    do_sweep(2, 1'b1, 1'b0, 1'b0);
    check("ne_wall_addr3", got_addr[3], 3); check("ne_wall_opp3", got_opp[3], 1);

    do_sweep(6, 1'b1, 1'b1, 1'b0);
    check("sw_wrap_addr8", got_addr[8], 3);

    bar_mem[5] = 1'b1;
    do_sweep(0, 1'b0, 1'b0, 1'b0);
    check("rest_addr5", got_addr[5], 5); check("rest_opp5", got_opp[5], 0);
    bar_mem[5] = 1'b0;

    do_sweep(9, 1'b0, 1'b0, 1'b0);
    check("bad_dir_err", err, 1);
    do_sweep(7, 1'b0, 1'b0, 1'b0);
    check("err_cleared", err, 0);
    check("w_wall_addr4", got_addr[4], 4); check("w_wall_opp4", got_opp[4], 1);

    // Asynchronous reset in the middle of a sweep
    clear_stats();
    push_sweep(3, 1'b1, 1'b0);
    @(posedge clk); #1;
    c0 = cyc; dir = 4'd3; wrap_x = 1'b1; wrap_y = 1'b0; start = 1'b1;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; start = 1'b0; end
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);   check("abort_rd_en", rd_en, 0); check("abort_wr_en", wr_en, 0);
    check("abort_done", done, 0);   check("abort_count", sweep_count, 0);
    check("abort_wr_addr", wr_addr, 0); check("abort_wr_data", wr_data, 0); check("abort_wr_opp", wr_opp, 0);
    check("writes_before_reset", n_wr, 3);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("writes_after_reset", n_wr, 3);
    check("idle_after_abort", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
